// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame aligner.
// Holds the FSM state encoding, lane/sample widths and the default frame pattern.
package adc_frame_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED
  } state_e;

  localparam int LANE_W   = 8;
  localparam int SAMPLE_W = 2 * LANE_W;

  localparam logic [LANE_W-1:0] DEFAULT_FRAME_PATTERN = 8'hF0;

endpackage

// File: rtl/adc_frame_aligner_sample_interleave.sv
// Pure bit mapping of the two DDR lane words into one ADC sample.
// Lane A carries the odd sample bits and lane B the even ones.
module sample_interleave
  import adc_frame_pkg::*;
(
  input  logic [LANE_W-1:0]   lane_a_i,
  input  logic [LANE_W-1:0]   lane_b_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  for (genvar i = 0; i < LANE_W; i++) begin : g_bit
    assign sample_o[2*i+1] = lane_a_i[i];
    assign sample_o[2*i]   = lane_b_i[i];
  end

endmodule

// File: rtl/adc_frame_aligner.sv
// Frame-clock alignment FSM for the 2-lane ADC ISERDES capture path.
// Slips the ISERDES until the frame word matches, then emits qualified samples.
module adc_frame_aligner
  import adc_frame_pkg::*;
#(
  parameter logic [LANE_W-1:0] FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
  parameter int                SETTLE_CYCLES = 4,
  parameter int                LOCK_COUNT    = 16,
  parameter int                MISS_LIMIT    = 4
) (
  input  logic                sample_clk,
  input  logic                reset_n,
  input  logic [LANE_W-1:0]   frame_word,
  input  logic [LANE_W-1:0]   lane_a,
  input  logic [LANE_W-1:0]   lane_b,
  input  logic                realign,
  output logic                bitslip,
  output logic                locked,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic [2:0]          slip_count,
  output logic                align_err
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT);
  localparam logic [7:0] MISS_LAST   = 8'(MISS_LIMIT);

  state_e              state_q;
  logic [3:0]          settle_q;
  logic [7:0]          match_q;
  logic [7:0]          miss_q;
  logic [2:0]          slip_cnt_q;
  logic                align_err_q;
  logic                bitslip_q;
  logic                locked_q;
  logic                valid_q;
  logic [SAMPLE_W-1:0] sample_q;

  logic [SAMPLE_W-1:0] sample_d;
  logic                match_d;

  assign match_d = (frame_word == FRAME_PATTERN);

  sample_interleave u_interleave (
    .lane_a_i (lane_a),
    .lane_b_i (lane_b),
    .sample_o (sample_d)
  );

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SETTLE;
      settle_q    <= SETTLE_INIT;
      match_q     <= '0;
      miss_q      <= '0;
      slip_cnt_q  <= '0;
      align_err_q <= 1'b0;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      valid_q     <= 1'b0;
      sample_q    <= '0;
    end else begin
      bitslip_q <= 1'b0;
      locked_q  <= (state_q == ST_LOCKED);
      valid_q   <= (state_q == ST_LOCKED) && match_d;
      sample_q  <= sample_d;

      // realign wins over everything, including the cycle that would have slipped
      if (realign) begin
        state_q     <= ST_SETTLE;
        settle_q    <= SETTLE_INIT;
        match_q     <= '0;
        miss_q      <= '0;
        slip_cnt_q  <= '0;
        align_err_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_SETTLE: begin
            if (settle_q <= 4'd1) begin
              state_q <= ST_CHECK;
              match_q <= '0;
            end else begin
              settle_q <= settle_q - 4'd1;
            end
          end
          ST_CHECK: begin
            if (match_d) begin
              if (match_q + 8'd1 == LOCK_LAST) begin
                state_q <= ST_LOCKED;
                miss_q  <= '0;
              end else begin
                match_q <= match_q + 8'd1;
              end
            end else begin
              match_q <= '0;
              state_q <= ST_SLIP;
            end
          end
          ST_SLIP: begin
            // pulse leaves with the SLIP->SETTLE transition so realign can still veto it
            bitslip_q  <= 1'b1;
            slip_cnt_q <= slip_cnt_q + 3'd1;
            if (slip_cnt_q == 3'd7) begin
              align_err_q <= 1'b1;
            end
            state_q  <= ST_SETTLE;
            settle_q <= SETTLE_INIT;
          end
          ST_LOCKED: begin
            if (match_d) begin
              miss_q <= '0;
            end else if (miss_q + 8'd1 == MISS_LAST) begin
              state_q <= ST_CHECK;
              match_q <= '0;
            end else begin
              miss_q <= miss_q + 8'd1;
            end
          end
          default: begin
            state_q  <= ST_SETTLE;
            settle_q <= SETTLE_INIT;
          end
        endcase
      end
    end
  end

  assign bitslip      = bitslip_q;
  assign locked       = locked_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign slip_count   = slip_cnt_q;
  assign align_err    = align_err_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Directed bench for adc_frame_aligner with an ISERDES bitslip model.
// Sample expectations flow through a queue scoreboard; control outputs are checked inline.
module tb_adc_frame_aligner;

  logic        sample_clk;
  logic        reset_n;
  logic [7:0]  frame_word;
  logic [7:0]  lane_a;
  logic [7:0]  lane_b;
  logic        realign;
  logic        bitslip;
  logic        locked;
  logic [15:0] sample;
  logic        sample_valid;
  logic [2:0]  slip_count;
  logic        align_err;

  logic [7:0]  fr_raw, la_raw, lb_raw;
  logic [2:0]  rot;
  logic        slip_d1;
  logic        model_clr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        v;
  } exp_t;
  exp_t sb_q[$];

  adc_frame_aligner dut (
    .sample_clk   (sample_clk),
    .reset_n      (reset_n),
    .frame_word   (frame_word),
    .lane_a       (lane_a),
    .lane_b       (lane_b),
    .realign      (realign),
    .bitslip      (bitslip),
    .locked       (locked),
    .sample       (sample),
    .sample_valid (sample_valid),
    .slip_count   (slip_count),
    .align_err    (align_err)
  );

  initial sample_clk = 1'b0;
  always #5 sample_clk = ~sample_clk;

  function automatic logic [7:0] rotl8(input logic [7:0] w, input logic [2:0] n);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) r = {r[6:0], r[7]};
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_il(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [2:0]  bi;
    for (int j = 0; j < 16; j++) begin
      bi = 3'(j >> 1);
      r[j] = (j % 2 == 1) ? a[bi] : b[bi];
    end
    return r;
  endfunction

  // ISERDES model: a slip pulse rotates all three words, effective two cycles later
  always @(posedge sample_clk) begin
    if (model_clr) begin
      rot     <= 3'd0;
      slip_d1 <= 1'b0;
    end else begin
      slip_d1 <= bitslip;
      if (slip_d1) rot <= rot + 3'd1;
    end
  end

  assign frame_word = rotl8(fr_raw, rot);
  assign lane_a     = rotl8(la_raw, rot);
  assign lane_b     = rotl8(lb_raw, rot);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] fr);
    reset_n   = 1'b0;
    model_clr = 1'b1;
    realign   = 1'b0;
    fr_raw    = fr;
    repeat (3) tick();
    reset_n   = 1'b1;
    model_clr = 1'b0;
  endtask

  // Drive one frame while LOCKED is known, queue the expectation, compare after the edge.
  task automatic sb_step(input string tag, input logic [7:0] fr, input logic [7:0] la,
                         input logic [7:0] lb, input logic exp_v);
    exp_t e;
    exp_t got;
    fr_raw = fr;
    la_raw = la;
    lb_raw = lb;
    e.s = ref_il(rotl8(la, rot), rotl8(lb, rot));
    e.v = exp_v;
    sb_q.push_back(e);
    tick();
    got = sb_q.pop_front();
    chk({tag, "_sample"}, 32'(sample), 32'(got.s));
    chk({tag, "_valid"}, 32'(sample_valid), 32'(got.v));
  endtask

  initial begin
    int lock_cyc;
    int pulses;
    int last;
    int min_gap;
    int consec;
    int early_err;
    int sc7, sc8, err8;
    int quiet;
    logic prev;
    logic lk;
    logic seen;

    reset_n   = 1'b0;
    realign   = 1'b0;
    model_clr = 1'b1;
    fr_raw    = 8'hF0;
    la_raw    = 8'hA5;
    lb_raw    = 8'h3C;
    repeat (3) tick();
    chk("rst_bitslip", 32'(bitslip), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_slip_count", 32'(slip_count), 0);
    chk("rst_align_err", 32'(align_err), 0);

    // aligned start
    reset_n   = 1'b1;
    model_clr = 1'b0;
    lock_cyc  = 0;
    pulses    = 0;
    for (int k = 1; k <= 40 && lock_cyc == 0; k++) begin
      tick();
      if (bitslip) pulses++;
      if (locked) lock_cyc = k;
    end
    chk("aligned_lock_cycle", 32'(lock_cyc), 21);
    chk("aligned_no_slip", 32'(pulses), 0);
    chk("aligned_slip_count", 32'(slip_count), 0);

    // interleave
    sb_step("il_0d", 8'hF0, 8'h02, 8'h03, 1'b1);
    chk("il_const_000d", 32'(sample), 32'h000D);
    sb_step("il_aaaa", 8'hF0, 8'hFF, 8'h00, 1'b1);
    chk("il_const_aaaa", 32'(sample), 32'hAAAA);
    sb_step("il_5555", 8'hF0, 8'h00, 8'hFF, 1'b1);
    sb_step("il_mix", 8'hF0, 8'h96, 8'h5B, 1'b1);

    // lock loss: three misses hold lock, a match resets the miss count
    for (int i = 0; i < 3; i++) begin
      sb_step("miss3", 8'h00, 8'(8'h11 * i), 8'(8'h22 + i), 1'b0);
      chk("miss3_locked", 32'(locked), 1);
    end
    sb_step("miss3_recover", 8'hF0, 8'h12, 8'h34, 1'b1);
    chk("miss3_recover_locked", 32'(locked), 1);
    for (int i = 0; i < 4; i++) begin
      sb_step("miss4", 8'h0F, 8'(8'h40 + i), 8'(8'hC0 - i), 1'b0);
      chk("miss4_locked_still", 32'(locked), 1);
    end
    sb_step("miss4_after", 8'hF0, 8'h77, 8'h88, 1'b0);
    chk("miss4_locked_fell", 32'(locked), 0);
    chk("miss4_no_slip", 32'(bitslip), 0);
    lock_cyc = 0;
    pulses   = 0;
    for (int k = 1; k <= 40 && lock_cyc == 0; k++) begin
      tick();
      if (bitslip) pulses++;
      if (locked) lock_cyc = k;
    end
    chk("relock_cycles", 32'(lock_cyc), 16);
    chk("relock_no_slip", 32'(pulses), 0);

    // offset of three bits
    la_raw = 8'h00;
    lb_raw = 8'h00;
    do_reset(8'h1E);
    pulses  = 0;
    last    = -100;
    min_gap = 1000;
    consec  = 0;
    prev    = 1'b0;
    lk      = 1'b0;
    for (int k = 1; k <= 200 && !lk; k++) begin
      tick();
      if (bitslip) begin
        pulses++;
        if (pulses > 1 && (k - last) < min_gap) min_gap = k - last;
        last = k;
      end
      if (bitslip && prev) consec++;
      prev = bitslip;
      if (locked) lk = 1'b1;
    end
    chk("off3_locked", 32'(lk), 1);
    chk("off3_pulses", 32'(pulses), 3);
    chk("off3_gap_ge6", 32'(min_gap >= 6), 1);
    chk("off3_no_back_to_back", 32'(consec), 0);
    chk("off3_slip_count", 32'(slip_count), 3);
    chk("off3_align_err", 32'(align_err), 0);

    // stuck pattern
    do_reset(8'h00);
    pulses    = 0;
    early_err = 0;
    sc7       = -1;
    sc8       = -1;
    err8      = -1;
    last      = -100;
    min_gap   = 1000;
    for (int k = 1; k <= 200 && pulses < 8; k++) begin
      tick();
      if (bitslip) begin
        pulses++;
        if (pulses > 1 && (k - last) < min_gap) min_gap = k - last;
        last = k;
        if (pulses < 8 && align_err) early_err++;
        if (pulses == 7) sc7 = int'(slip_count);
        if (pulses == 8) begin
          sc8  = int'(slip_count);
          err8 = int'(align_err);
        end
      end
    end
    chk("stuck_pulses", 32'(pulses), 8);
    chk("stuck_gap_ge6", 32'(min_gap >= 6), 1);
    chk("stuck_no_early_err", 32'(early_err), 0);
    chk("stuck_slip_count_7", 32'(sc7), 7);
    chk("stuck_align_err_8th", 32'(err8), 1);
    chk("stuck_slip_count_wrap", 32'(sc8), 0);

    // realign landing on the SLIP cycle
    quiet = 0;
    repeat (5) begin
      tick();
      if (bitslip) quiet++;
    end
    chk("pre_realign_quiet", 32'(quiet), 0);
    realign   = 1'b1;
    model_clr = 1'b1;
    fr_raw    = 8'hF0;
    tick();
    realign   = 1'b0;
    model_clr = 1'b0;
    chk("realign_no_pulse", 32'(bitslip), 0);
    chk("realign_slip_count", 32'(slip_count), 0);
    chk("realign_align_err", 32'(align_err), 0);
    lock_cyc = 0;
    pulses   = 0;
    for (int k = 1; k <= 40 && lock_cyc == 0; k++) begin
      tick();
      if (bitslip) pulses++;
      if (locked) lock_cyc = k;
    end
    chk("realign_lock_cycle", 32'(lock_cyc), 21);
    chk("realign_no_slip", 32'(pulses), 0);

    // asynchronous reset during SETTLE while a bitslip pulse is high
    la_raw = 8'h5A;
    lb_raw = 8'hC3;
    do_reset(8'h00);
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (bitslip) seen = 1'b1;
    end
    chk("pre_rst_bitslip", 32'(bitslip), 1);
    chk("pre_rst_slip_count", 32'(slip_count), 1);
    chk("pre_rst_sample", 32'(sample), 32'(ref_il(8'h5A, 8'hC3)));
    reset_n = 1'b0;
    #1;
    chk("async_rst_bitslip", 32'(bitslip), 0);
    chk("async_rst_slip_count", 32'(slip_count), 0);
    chk("async_rst_sample", 32'(sample), 0);
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_valid", 32'(sample_valid), 0);
    chk("async_rst_align_err", 32'(align_err), 0);
    #2;
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_frame_aligner.md
# adc_frame_aligner

Downstream of the Spartan-6 ISERDES capture stage for the 2-lane LTC ADC interface, in the `sample_clk` domain. Watches the deserialized frame-clock word. Issues single-cycle `bitslip` pulses back to the ISERDES until the word matches the expected frame pattern, then holds lock. Once locked, interleaves the two 8-bit DDR lane words into one 16-bit ADC sample per `sample_clk` and qualifies it with `sample_valid`.

## Interface
- `FRAME_PATTERN`, 8'hF0: expected deserialized frame-clock word when aligned.
- `SETTLE_CYCLES`, 4: cycles ignored after each bitslip or realign (ISERDES settle time); range 1–15.
- `LOCK_COUNT`, 16: consecutive matches required to declare lock; range 1–255.
- `MISS_LIMIT`, 4: consecutive mismatches in LOCKED that drop lock; range 1–255.
- `sample_clk`  in  1  ISERDES word clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_word`  in  8  deserialized frame-clock lane, MSB = first bit received.
- `lane_a`  in  8  deserialized lane A (`out_a`), MSB first.
- `lane_b`  in  8  deserialized lane B (`out_b`), MSB first.
- `realign`  in  1  single-cycle request to restart alignment.
- `bitslip`  out  1  one-cycle pulse to the ISERDES bitslip input.
- `locked`  out  1  high while in LOCKED.
- `sample`  out  16  interleaved ADC sample.
- `sample_valid`  out  1  `sample` is from an aligned, pattern-matching frame.
- `slip_count`  out  3  bitslips issued since the last reset/realign, mod 8.
- `align_err`  out  1  sticky: 8 or more slips issued without reaching lock.

## Operation
- States: SETTLE, CHECK, SLIP, LOCKED.
- On reset, the FSM enters SETTLE with the settle counter at `SETTLE_CYCLES`. All outputs are 0.
- SETTLE: ignores `frame_word` and decrements the counter. Moves to CHECK after `SETTLE_CYCLES` cycles with `match_cnt` = 0.
- CHECK, match (`frame_word == FRAME_PATTERN`):
  - increments `match_cnt`;
  - on reaching `LOCK_COUNT`, goes to LOCKED with `miss_cnt` = 0.
- CHECK, mismatch: clears `match_cnt` and goes to SLIP.
- SLIP: lasts one cycle.
  - `bitslip` = 1 and `slip_count` increments (wraps 7 → 0).
  - If `slip_count` was 7, `align_err` sets; it stays set until reset or `realign`.
  - Then SETTLE. Searching never stops; `align_err` is only a flag.
- LOCKED, match: clears `miss_cnt`.
- LOCKED, mismatch: increments `miss_cnt`. On reaching `MISS_LIMIT`, goes to CHECK with `match_cnt` = 0.
  - No slip is issued on lock loss; slipping resumes only if CHECK then sees a mismatch.
- `realign` has priority over every state, including mid-SLIP. The FSM goes to SETTLE and clears all counters, `slip_count` and `align_err`. No bitslip is issued that cycle.
- Interleave, following the ADC's 2-lane order where A carries odd bits and the first bit received is the MSB: `sample[2i+1] = lane_a[i]`, `sample[2i] = lane_b[i]` for i = 0..7.

## Timing
- `sample` is registered: lanes at cycle n appear at n+1. It updates every cycle, locked or not.
- `sample_valid` at n+1 = (state at n is LOCKED) AND (`frame_word` at n matches). A mismatching word is flagged invalid even before lock drops.
- `locked` is registered from the state: it rises the cycle after the `LOCK_COUNT`-th match and falls the cycle after the `MISS_LIMIT`-th miss.
- `bitslip`:
  - never high on two consecutive cycles;
  - minimum spacing between pulses is 1 + `SETTLE_CYCLES` + 1 cycles (slip, settle, check).
- Reset asserted mid-operation: all outputs clear asynchronously, including an active `bitslip` pulse.
- After `reset_n` deasserts, the first possible `locked` is at cycle `SETTLE_CYCLES` + `LOCK_COUNT` + 1.

## Structure
- Package `adc_frame_pkg`:
  - state enum (SETTLE, CHECK, SLIP, LOCKED);
  - lane width (8) and sample width (16) constants;
  - default `FRAME_PATTERN`.
- Sub-module `sample_interleave`: pure bit-mapping of `lane_a`/`lane_b` to 16 bits. The top-level registers its output.
- All counters, the FSM and the output registers live in the top module.

## Test plan
Bench models the ISERDES: each `bitslip` rotates all three words left by 1 bit, applied 2 cycles after the pulse. Defaults are used unless stated.
- Aligned start: `frame_word` = 0xF0 → no bitslip; `locked` rises at cycle 21 after reset release; `slip_count` = 0.
- Offset 3: initial `frame_word` = 0x1E → exactly 3 bitslip pulses, each ≥ 6 cycles apart → lock; `slip_count` = 3; `align_err` = 0.
- Interleave: lanes tuned so the sample is 0x000D (`lane_a` = 0x02, `lane_b` = 0x03) → `sample` = 0x000D and `sample_valid` = 1 one cycle later.
- Lock loss: in LOCKED, force 3 mismatches then a match → lock held, 3 invalid samples. Then 4 mismatches → `locked` falls and CHECK resumes.
- Stuck pattern: `frame_word` fixed at 0x00 → continuous slips; `align_err` sets on the 8th pulse; `slip_count` wraps to 0.
- `realign` asserted coinciding with a SLIP, and `reset_n` pulsed low mid-SETTLE:
  - on `realign`, no pulse that cycle, all counters and `align_err` clear, and the full settle → check → lock sequence repeats;
  - on reset, all outputs go to 0 immediately.
